// File: rtl/uart_bus_master_pkg.sv
// uart_bus_master_pkg: shared constants and FSM encoding for the UART bus master.
package uart_bus_master_pkg;
    localparam logic [1:0] TX_DATA  = 2'b00;
    localparam logic [1:0] RX_DATA  = 2'b01;
    localparam logic [1:0] FREQ_DIV = 2'b10;
    localparam logic WE_WRITE = 1'b0;
    localparam logic WE_READ  = 1'b1;
    typedef enum logic [1:0] {IDLE, STROBE, RELEASE} state_t;
endpackage

// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: fixed-priority (div > tx > rd) request select, ready only while idle.
module uart_bus_arbiter
    import uart_bus_master_pkg::*;
(
    input  logic       idle,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       div_valid,
    input  logic [7:0] div_data,
    input  logic       rd_req,
    output logic       tx_ready,
    output logic       div_ready,
    output logic       rd_ready,
    output logic       sel_valid,
    output logic [1:0] sel_addr,
    output logic [7:0] sel_data,
    output logic       sel_we
);
    always_comb begin
        div_ready = idle & div_valid;
        tx_ready  = idle & tx_valid & !div_valid;
        rd_ready  = idle & rd_req & !div_valid & !tx_valid;
        sel_valid = div_ready | tx_ready | rd_ready;
        sel_addr  = div_valid ? FREQ_DIV : tx_valid ? TX_DATA : RX_DATA;
        sel_data  = div_valid ? div_data : tx_valid ? tx_data : 8'h00;
        sel_we    = (div_valid | tx_valid) ? WE_WRITE : WE_READ;
    end
endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: serialises TX/RX/divider requests into four-phase stb/clk/ack
// UART register transactions with per-phase ack timeout.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       div_valid,
    input  logic [7:0] div_data,
    output logic       div_ready,
    input  logic       rd_req,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       timeout_err,
    output logic [1:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    output logic       bus_we,
    output logic       bus_clk,
    output logic       bus_stb,
    input  logic       bus_ack
);
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             sel_valid, sel_we, got, expired;
    logic [1:0]       sel_addr;
    logic [7:0]       sel_data;

    uart_bus_arbiter u_arb (
        .idle      (state == IDLE),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .div_valid (div_valid),
        .div_data  (div_data),
        .rd_req    (rd_req),
        .tx_ready  (tx_ready),
        .div_ready (div_ready),
        .rd_ready  (rd_ready),
        .sel_valid (sel_valid),
        .sel_addr  (sel_addr),
        .sel_data  (sel_data),
        .sel_we    (sel_we)
    );

    assign busy = state != IDLE;

    // got: the ack level awaited by the current phase has arrived
    always_comb begin
        state_nx = state;
        got      = 1'b0;
        expired  = 1'b0;
        case (state)
            IDLE: state_nx = sel_valid ? STROBE : IDLE;
            STROBE, RELEASE: begin
                got      = (state == STROBE) ? bus_ack : !bus_ack;
                expired  = !got && cnt == CNT_W'(ACK_TIMEOUT - 1);
                state_nx = got ? ((state == STROBE) ? RELEASE : IDLE) : expired ? IDLE : state;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bus_stb     <= 1'b0;
            bus_clk     <= 1'b0;
            bus_we      <= WE_READ;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= (state != IDLE && state_nx == state) ? cnt + 1'b1 : '0;
            rd_valid    <= state == RELEASE && got && bus_we == WE_READ;
            timeout_err <= expired;
            if (state == IDLE && sel_valid) begin
                bus_addr  <= sel_addr;
                bus_wdata <= sel_data;
                bus_we    <= sel_we;
                bus_stb   <= 1'b1;
                bus_clk   <= 1'b1;
            end
            if (state == STROBE && got) begin
                bus_clk <= 1'b0;
                if (bus_we == WE_READ) rd_data <= bus_rdata;
            end
            if ((state == RELEASE && got) || expired) begin
                bus_stb <= 1'b0;
                bus_clk <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed and random transactions against a registered-ack UART slave model.
module tb_uart_bus_master;
    localparam int TO = 16;
    logic clk = 0, reset = 1;
    logic tx_valid = 0, div_valid = 0, rd_req = 0;
    logic [7:0] tx_data = 0, div_data = 0;
    logic tx_ready, div_ready, rd_ready, rd_valid, busy, timeout_err;
    logic [7:0] rd_data, bus_wdata, bus_rdata;
    logic [1:0] bus_addr;
    logic bus_we, bus_clk, bus_stb, bus_ack;
    logic slave_ack = 0, no_ack = 0, ack_force = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [9:0] wlog[$];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    uart_bus_master #(.ACK_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .div_valid(div_valid), .div_data(div_data), .div_ready(div_ready),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .timeout_err(timeout_err),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_we(bus_we), .bus_clk(bus_clk), .bus_stb(bus_stb), .bus_ack(bus_ack)
    );

    // Slave acks one edge after seeing stb&clk and logs every write strobe it sees
    always @(posedge clk) begin
        if (bus_stb && bus_clk && !bus_ack && !bus_we) wlog.push_back({bus_addr, bus_wdata});
        slave_ack <= reset ? 1'b0 : (no_ack ? 1'b0 : (bus_stb & bus_clk));
    end
    assign bus_ack   = slave_ack | ack_force;
    assign bus_rdata = rx_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from idle; exp_cyc = edges from acceptance until busy drops
    task automatic txn(input string tag, input bit dv, input bit tv, input bit rv,
                       input logic [7:0] dd, input logic [7:0] td, input int exp_cyc, input bit exp_to);
        int kind, cyc, rdv, tos, stbc;
        logic [7:0] exp_w;
        kind = dv ? 2 : tv ? 0 : 1;
        exp_w = (kind == 2) ? dd : (kind == 0) ? td : 8'h00;
        div_valid = dv; div_data = dd; tx_valid = tv; tx_data = td; rd_req = rv;
        #1;
        chk({tag, "_ready"}, {29'd0, div_ready, tx_ready, rd_ready}, {29'd0, dv, tv && !dv, rv && !dv && !tv});
        tick();
        div_valid = 0; tx_valid = 0; rd_req = 0;
        chk({tag, "_bus"}, {21'd0, bus_addr, bus_we, bus_wdata, bus_stb, bus_clk},
            {21'd0, 2'(kind), kind == 1, exp_w, 2'b11});
        cyc = 1; rdv = 0; tos = 0; stbc = bus_stb;
        while (busy && cyc < 200) begin
            if (cyc == 2) begin
                tx_valid = 1; div_valid = 1; rd_req = 1;
                #1;
                chk({tag, "_busy_ready"}, {29'd0, div_ready, tx_ready, rd_ready}, 0);
                tx_valid = 0; div_valid = 0; rd_req = 0;
            end
            tick();
            cyc++;
            rdv += rd_valid;
            tos += timeout_err;
            stbc += bus_stb;
        end
        chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_stb_cycles"}, stbc, exp_cyc - 1);
        chk({tag, "_rd_valid"}, rdv, (kind == 1 && !exp_to) ? 1 : 0);
        chk({tag, "_timeout"}, tos, exp_to ? 1 : 0);
        if (kind == 1 && !exp_to) chk({tag, "_rd_data"}, rd_data, rx_byte);
        if (kind != 1 && !ack_force) begin
            chk({tag, "_wlog"}, wlog.size() == 1 ? {22'd0, wlog[0]} : 32'hFFFF_FFFF, {22'd0, 2'(kind), exp_w});
        end
        wlog.delete();
        tick();
        chk({tag, "_idle"}, {28'd0, bus_stb, bus_clk, rd_valid, timeout_err}, 0);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_bus", {19'd0, bus_stb, bus_clk, bus_we, bus_addr, bus_wdata},
            {19'd0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00});
        chk("reset_out", {22'd0, rd_valid, timeout_err, rd_data}, 0);
        reset = 0;
        tick();
        chk("idle_busy", busy, 0);

        txn("tx41", 0, 1, 0, 8'h00, 8'h41, 5, 0);
        txn("div27", 1, 1, 0, 8'h27, 8'h55, 5, 0);
        txn("tx55", 0, 1, 0, 8'h00, 8'h55, 5, 0);
        rx_byte = 8'h5A;
        txn("rd5a", 0, 0, 1, 8'h00, 8'h00, 5, 0);

        tx_valid = 1; #1; tx_valid = 0;
        tick();
        chk("drop_valid", {30'd0, busy, bus_stb}, 0);

        no_ack = 1;
        txn("noack", 0, 0, 1, 8'h00, 8'h00, TO + 1, 1);
        no_ack = 0;
        rx_byte = 8'hC3;
        txn("after_to", 0, 0, 1, 8'h00, 8'h00, 5, 0);

        ack_force = 1;
        txn("stuck", 0, 0, 1, 8'h00, 8'h00, TO + 2, 1);
        ack_force = 0;
        tick();

        tx_valid = 1; tx_data = 8'hAA;
        tick();
        tx_valid = 0;
        tick(); tick();
        chk("rel_phase", {30'd0, bus_stb, bus_clk}, 2'b10);
        reset = 1;
        tick();
        reset = 0;
        chk("rst_mid", {28'd0, bus_stb, bus_clk, busy, rd_valid | timeout_err}, 0);
        wlog.delete();
        txn("tx33", 0, 1, 0, 8'h00, 8'h33, 5, 0);

        for (int i = 0; i < 20; i++) begin
            bit dv, tv, rv;
            dv = 1'($urandom); tv = 1'($urandom); rv = 1'($urandom);
            if (!dv && !tv) rv = 1;
            rx_byte = 8'($urandom);
            txn($sformatf("rand%0d", i), dv, tv, rv, 8'($urandom), 8'($urandom), 5, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
